// File: rtl/iserdes2_align_ctl.sv
`default_nettype none
// ============================================================================
// Module      : iserdes2_align_ctl
// Description : Calibration and word-alignment sequencer for the dual-lane
//               ISERDES2/IODELAY2 ADC capture PHY. Runs the IODELAY2 CAL/RST
//               handshake against the slave BUSY, then issues BITSLIP pulses
//               until the frame lane shows the expected pattern, and realigns
//               whenever lock is lost.
// Revision    : 1.0 - initial release
// ============================================================================
module iserdes2_align_ctl #(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SETTLE_CYCLES = 3,
  parameter int         BUSY_TIMEOUT  = 255,
  parameter int         LOSS_COUNT    = 2
) (
  input  logic       clkdiv,
  input  logic       reset,
  input  logic       start,
  input  logic       busy,
  input  logic [7:0] frame,
  output logic       cal_master,
  output logic       cal_slave,
  output logic       rst_dly,
  output logic       bitslip,
  output logic       aligned,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [7:0] relock_cnt
);

  localparam logic [7:0] c_tmo_limit   = 8'(BUSY_TIMEOUT);
  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_match_tgt   = 4'(MATCH_COUNT);
  localparam logic [3:0] c_loss_tgt    = 4'(LOSS_COUNT);
  localparam logic [3:0] c_slip_max    = 4'(DATA_WIDTH);

  localparam logic [1:0] c_code_cal   = 2'd1;
  localparam logic [1:0] c_code_rst   = 2'd2;
  localparam logic [1:0] c_code_align = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CAL    = 4'd1,
    S_CAL_HI = 4'd2,
    S_CAL_LO = 4'd3,
    S_RST    = 4'd4,
    S_RST_LO = 4'd5,
    S_CHECK  = 4'd6,
    S_SLIP   = 4'd7,
    S_SETTLE = 4'd8,
    S_LOCKED = 4'd9,
    S_FAIL   = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tmo_cnt;
  logic [3:0] r_slip_cnt;
  logic [3:0] w_slip_nxt;
  logic [3:0] r_match_cnt;
  logic [3:0] w_match_nxt;
  logic [3:0] r_loss_cnt;
  logic [3:0] w_loss_nxt;
  logic [1:0] w_fail_code_nxt;
  logic [7:0] w_relock_nxt;
  logic       w_match;
  logic       w_tmo_hit;
  logic [3:0] w_match_inc;
  logic [3:0] w_loss_inc;

  assign w_match     = (frame[DATA_WIDTH-1:0] == FRAME_PATTERN[DATA_WIDTH-1:0]);
  assign w_tmo_hit   = (r_tmo_cnt == c_tmo_limit);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_loss_inc  = r_loss_cnt + 4'd1;

  // State register
  always_ff @(posedge clkdiv or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-counter decode; counters not written below hold or clear
  always_comb begin
    w_state_nxt     = r_state;
    w_slip_nxt      = r_slip_cnt;
    w_match_nxt     = 4'd0;
    w_loss_nxt      = 4'd0;
    w_fail_code_nxt = fail_code;
    w_relock_nxt    = relock_cnt;
    case (r_state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          w_state_nxt     = S_CAL;
          w_fail_code_nxt = 2'd0;
          w_slip_nxt      = 4'd0;
        end
      end
      S_CAL: w_state_nxt = S_CAL_HI;
      S_CAL_HI: begin
        if (busy) begin
          w_state_nxt = S_CAL_LO;
        end else if (w_tmo_hit) begin
          w_state_nxt     = S_FAIL;
          w_fail_code_nxt = c_code_cal;
        end
      end
      S_CAL_LO: begin
        if (!busy) begin
          w_state_nxt = S_RST;
        end else if (w_tmo_hit) begin
          w_state_nxt     = S_FAIL;
          w_fail_code_nxt = c_code_cal;
        end
      end
      S_RST: w_state_nxt = S_RST_LO;
      S_RST_LO: begin
        // BUSY lags the RST pulse by a cycle, so the entry cycle is ignored
        if (r_tmo_cnt != 8'd0) begin
          if (!busy) begin
            w_state_nxt = S_CHECK;
          end else if (w_tmo_hit) begin
            w_state_nxt     = S_FAIL;
            w_fail_code_nxt = c_code_rst;
          end
        end
      end
      S_CHECK: begin
        if (w_match) begin
          if (w_match_inc == c_match_tgt) w_state_nxt = S_LOCKED;
          else                            w_match_nxt = w_match_inc;
        end else if (r_slip_cnt < c_slip_max) begin
          w_state_nxt = S_SLIP;
        end else begin
          w_state_nxt     = S_FAIL;
          w_fail_code_nxt = c_code_align;
        end
      end
      S_SLIP: begin
        w_slip_nxt  = r_slip_cnt + 4'd1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_tmo_cnt == c_settle_last) w_state_nxt = S_CHECK;
      end
      S_LOCKED: begin
        if (start) begin
          w_state_nxt     = S_CAL;
          w_fail_code_nxt = 2'd0;
          w_slip_nxt      = 4'd0;
        end else if (!w_match) begin
          if (w_loss_inc == c_loss_tgt) begin
            // Realign only; the delay calibration is still valid
            w_state_nxt  = S_CHECK;
            w_slip_nxt   = 4'd0;
            w_relock_nxt = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
          end else begin
            w_loss_nxt = w_loss_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters and registered outputs; pulses are decoded from the next state
  always_ff @(posedge clkdiv or posedge reset) begin
    if (reset) begin
      r_tmo_cnt   <= 8'd0;
      r_slip_cnt  <= 4'd0;
      r_match_cnt <= 4'd0;
      r_loss_cnt  <= 4'd0;
      cal_master  <= 1'b0;
      cal_slave   <= 1'b0;
      rst_dly     <= 1'b0;
      bitslip     <= 1'b0;
      aligned     <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      relock_cnt  <= 8'd0;
    end else begin
      r_tmo_cnt   <= (w_state_nxt != r_state) ? 8'd0 : r_tmo_cnt + 8'd1;
      r_slip_cnt  <= w_slip_nxt;
      r_match_cnt <= w_match_nxt;
      r_loss_cnt  <= w_loss_nxt;
      cal_master  <= (w_state_nxt == S_CAL);
      cal_slave   <= (w_state_nxt == S_CAL);
      rst_dly     <= (w_state_nxt == S_RST);
      bitslip     <= (w_state_nxt == S_SLIP);
      aligned     <= (w_state_nxt == S_LOCKED);
      fail        <= (w_state_nxt == S_FAIL);
      fail_code   <= w_fail_code_nxt;
      relock_cnt  <= w_relock_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iserdes2_align_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iserdes2_align_ctl
// Description : Directed bench for iserdes2_align_ctl with a small PHY model
//               (BUSY response, bitslip-dependent frame word) and an event
//               scoreboard fed by the stimulus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iserdes2_align_ctl;

  localparam logic [7:0] c_pat = 8'hF0;
  localparam logic [7:0] c_rot = 8'h87;   // c_pat rotated left by 3

  localparam logic [7:0] EV_UNLOCK = 8'd1;
  localparam logic [7:0] EV_CAL    = 8'd2;
  localparam logic [7:0] EV_RST    = 8'd3;
  localparam logic [7:0] EV_SLIP   = 8'd4;
  localparam logic [7:0] EV_LOCK   = 8'd5;
  localparam logic [7:0] EV_FAIL   = 8'd6;

  logic       clkdiv;
  logic       reset;
  logic       start;
  logic       busy;
  logic [7:0] frame;
  logic       cal_master, cal_slave, rst_dly, bitslip, aligned, fail;
  logic [1:0] fail_code;
  logic [7:0] relock_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ev_count = 0;

  // PHY model state
  int         cal_t = -1;
  int         rst_t = -1;
  int         slips = 0;
  int         need = 3;
  logic       busy_stuck = 1'b0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  logic [15:0] exp_q[$];
  int          slip_cyc[$];

  assign busy  = !busy_stuck && ((cal_t >= 5 && cal_t <= 7) || (rst_t >= 4 && rst_t <= 6));
  assign frame = force_en ? force_val : ((slips >= need) ? c_pat : c_rot);

  iserdes2_align_ctl dut (
    .clkdiv     (clkdiv),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame      (frame),
    .cal_master (cal_master),
    .cal_slave  (cal_slave),
    .rst_dly    (rst_dly),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .fail       (fail),
    .fail_code  (fail_code),
    .relock_cnt (relock_cnt)
  );

  initial begin
    clkdiv = 1'b0;
    forever #5 clkdiv = ~clkdiv;
  end

  initial begin
    forever begin
      @(posedge clkdiv);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input logic [15:0] obs);
    logic [15:0] exp;
    ev_count++;
    n_cmp++;
    if (exp_q.size() == 0) exp = 16'hFFFF;
    else                   exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL event observed=%h expected=%h", obs, exp);
    end
  endtask

  // PHY model and output-event monitor
  initial begin
    logic p_al, p_cal, p_rst, p_bs, p_fail;
    p_al = 0; p_cal = 0; p_rst = 0; p_bs = 0; p_fail = 0;
    forever begin
      @(negedge clkdiv);
      if (cal_master) cal_t = 0;
      else if (cal_t >= 0 && cal_t < 100) cal_t++;
      if (rst_dly) rst_t = 0;
      else if (rst_t >= 0 && rst_t < 100) rst_t++;
      if (bitslip && !p_bs) begin
        slips++;
        slip_cyc.push_back(cyc);
      end
      if (p_al && !aligned)                   check_ev({EV_UNLOCK, 8'h00});
      if (!p_cal && (cal_master || cal_slave)) check_ev({EV_CAL, 6'd0, cal_master, cal_slave});
      if (!p_rst && rst_dly)                   check_ev({EV_RST, 8'h00});
      if (!p_bs && bitslip)                    check_ev({EV_SLIP, 8'h00});
      if (!p_al && aligned)                    check_ev({EV_LOCK, relock_cnt});
      if (!p_fail && fail)                     check_ev({EV_FAIL, 6'd0, fail_code});
      p_al = aligned; p_cal = cal_master || cal_slave; p_rst = rst_dly;
      p_bs = bitslip; p_fail = fail;
    end
  end

  function automatic logic cond(input int what);
    case (what)
      0:       return aligned === 1'b1;
      1:       return aligned === 1'b0;
      2:       return fail === 1'b1;
      default: return bitslip === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int what, input int budget, input string tag);
    int n;
    n = 0;
    while (!cond(what) && n < budget) begin
      @(negedge clkdiv);
      n++;
    end
    chk(tag, 32'(cond(what)), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clkdiv);
    start = 1'b0;
  endtask

  // Directed sequence
  initial begin
    int t_cal;
    int t_fail;
    int snap;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clkdiv);
    chk("reset_outputs", {cal_master, cal_slave, rst_dly, bitslip, aligned, fail, fail_code, relock_cnt}, 0);
    reset = 1'b0;
    snap = ev_count;
    repeat (5) @(negedge clkdiv);
    chk("idle_without_start", 32'(ev_count - snap), 0);

    // Nominal: three slips needed, then lock after four matches
    need = 3;
    exp_q.push_back({EV_CAL, 8'h03});
    exp_q.push_back({EV_RST, 8'h00});
    repeat (3) exp_q.push_back({EV_SLIP, 8'h00});
    exp_q.push_back({EV_LOCK, 8'h00});
    pulse_start();
    chk("start_to_cal", {cal_master, cal_slave}, 2'b11);
    wait_for(0, 150, "nominal_lock");
    chk("nominal_relock", relock_cnt, 0);
    chk("nominal_queue", exp_q.size(), 0);

    // Single mismatch while locked must not drop lock
    force_en = 1'b1; force_val = 8'h00;
    @(negedge clkdiv);
    force_en = 1'b0;
    repeat (3) @(negedge clkdiv);
    chk("single_miss_keeps_lock", aligned, 1);

    // Persistent mismatch: lose lock and realign with two slips, no CAL
    exp_q.push_back({EV_UNLOCK, 8'h00});
    repeat (2) exp_q.push_back({EV_SLIP, 8'h00});
    exp_q.push_back({EV_LOCK, 8'h01});
    need = slips + 2;
    wait_for(1, 10, "loss_unlock");
    wait_for(0, 100, "loss_relock");
    chk("loss_relock_cnt", relock_cnt, 1);
    chk("loss_queue", exp_q.size(), 0);

    // Second loss; reset asynchronously while in SETTLE
    exp_q.push_back({EV_UNLOCK, 8'h00});
    exp_q.push_back({EV_SLIP, 8'h00});
    need = slips + 2;
    wait_for(3, 20, "second_loss_slip");
    chk("second_loss_relock_cnt", relock_cnt, 2);
    @(posedge clkdiv);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {cal_master, cal_slave, rst_dly, bitslip, aligned, fail, fail_code, relock_cnt}, 0);
    exp_q.delete();
    repeat (3) @(negedge clkdiv);
    reset = 1'b0;
    snap = ev_count;
    repeat (20) @(negedge clkdiv);
    chk("post_reset_idle_events", 32'(ev_count - snap), 0);
    chk("post_reset_idle_outputs", {aligned, fail, cal_master}, 0);

    // Immediate match: lock with zero slips
    need = slips;
    exp_q.push_back({EV_CAL, 8'h03});
    exp_q.push_back({EV_RST, 8'h00});
    exp_q.push_back({EV_LOCK, 8'h00});
    pulse_start();
    wait_for(0, 100, "zero_slip_lock");
    chk("zero_slip_queue", exp_q.size(), 0);

    // Restart from LOCKED
    exp_q.push_back({EV_UNLOCK, 8'h00});
    exp_q.push_back({EV_CAL, 8'h03});
    exp_q.push_back({EV_RST, 8'h00});
    exp_q.push_back({EV_LOCK, 8'h00});
    pulse_start();
    chk("restart_aligned_low", aligned, 0);
    chk("restart_cal_pulse", cal_master, 1);
    wait_for(0, 100, "restart_relock");
    chk("restart_queue", exp_q.size(), 0);

    // CAL timeout with BUSY stuck low
    busy_stuck = 1'b1;
    exp_q.push_back({EV_UNLOCK, 8'h00});
    exp_q.push_back({EV_CAL, 8'h03});
    exp_q.push_back({EV_FAIL, 8'h01});
    pulse_start();
    t_cal = cyc;
    chk("timeout_cal_pulse", cal_master, 1);
    wait_for(2, 400, "cal_timeout_fail");
    t_fail = cyc;
    chk("cal_timeout_cycles", 32'(t_fail - t_cal), 257);
    chk("cal_timeout_code", fail_code, 1);

    // Restart from FAIL into a lane that never aligns
    busy_stuck = 1'b0;
    force_en = 1'b1; force_val = 8'h00;
    slip_cyc.delete();
    exp_q.push_back({EV_CAL, 8'h03});
    exp_q.push_back({EV_RST, 8'h00});
    repeat (8) exp_q.push_back({EV_SLIP, 8'h00});
    exp_q.push_back({EV_FAIL, 8'h03});
    pulse_start();
    chk("fail_restart_cal", cal_master, 1);
    chk("fail_restart_clear", {fail, fail_code}, 0);
    wait_for(2, 200, "no_align_fail");
    chk("no_align_code", fail_code, 3);
    chk("no_align_slip_count", slip_cyc.size(), 8);
    for (int i = 1; i < slip_cyc.size(); i++)
      chk("slip_spacing", 32'(slip_cyc[i] - slip_cyc[i-1]), 5);
    repeat (4) @(negedge clkdiv);
    chk("final_queue", exp_q.size(), 0);
    chk("final_not_aligned", aligned, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
